// File: rtl/mem_lsq_station.sv
// Load/store reservation station: in-order head issue, a store queue that forwards
// to younger loads, and one cache request register shared by committed stores and loads.
module mem_lsq_station #(
   parameter int RS_DEPTH = 8,
   parameter int SQ_DEPTH = 8,
   parameter int TAG_BITS = 4,
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int N_CDB    = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       alloc_valid,
   output logic                       alloc_ready,
   input  logic                       alloc_is_store,
   input  logic [TAG_BITS-1:0]        alloc_tag,
   input  logic [ADDR_W-1:0]          alloc_offset,
   input  logic                       alloc_base_rdy,
   input  logic [DATA_W-1:0]          alloc_base_val,
   input  logic [TAG_BITS-1:0]        alloc_base_tag,
   input  logic                       alloc_data_rdy,
   input  logic [DATA_W-1:0]          alloc_data_val,
   input  logic [TAG_BITS-1:0]        alloc_data_tag,
   input  logic [N_CDB-1:0]           cdb_valid,
   input  logic [N_CDB*TAG_BITS-1:0]  cdb_tag,
   input  logic [N_CDB*DATA_W-1:0]    cdb_data,
   output logic                       st_done_valid,
   output logic [TAG_BITS-1:0]        st_done_tag,
   input  logic                       commit_st,
   output logic                       dc_req_valid,
   input  logic                       dc_req_ready,
   output logic                       dc_req_write,
   output logic [ADDR_W-1:0]          dc_req_addr,
   output logic [DATA_W-1:0]          dc_req_data,
   output logic [TAG_BITS-1:0]        dc_req_tag,
   output logic                       fwd_valid,
   output logic [TAG_BITS-1:0]        fwd_tag,
   output logic [DATA_W-1:0]          fwd_data,
   output logic [$clog2(RS_DEPTH):0]  rs_count,
   output logic [$clog2(SQ_DEPTH):0]  sq_count
);
   localparam int RPW = $clog2(RS_DEPTH);
   localparam int SPW = $clog2(SQ_DEPTH);

   typedef struct packed {
      logic                is_store;
      logic [TAG_BITS-1:0] tag;
      logic                addr_rdy;
      logic [TAG_BITS-1:0] base_tag;
      logic [ADDR_W-1:0]   addr;     // offset alone until the base arrives
      logic                data_rdy;
      logic [TAG_BITS-1:0] data_tag;
      logic [DATA_W-1:0]   data;
   } rs_entry_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } sq_entry_t;

   rs_entry_t rs_mem [RS_DEPTH];
   sq_entry_t sq_mem [SQ_DEPTH];
   logic [RPW:0] rs_head, rs_tail;
   logic [SPW:0] sq_head, sq_tail, sq_cmt;   // sq_cmt: oldest uncommitted entry
   logic [RPW-1:0] rh;
   rs_entry_t alloc_e;
   logic rs_empty, sq_full, head_ok, fwd_hit;
   logic [DATA_W-1:0] fwd_val;
   logic [SPW-1:0] fidx, wr_idx;
   logic [SPW:0] cmt_cnt;
   logic req_load_en, wr_inflight, issue_wr, issue_ld, push_st, do_fwd, rs_pop;
   logic do_alloc, do_commit, wr_free;

   function automatic logic cdb_hit(input logic [TAG_BITS-1:0] t);
      logic hit;
      hit = 1'b0;
      for (int k = 0; k < N_CDB; k++)
         if (cdb_valid[k] && cdb_tag[k*TAG_BITS +: TAG_BITS] == t) hit = 1'b1;
      return hit;
   endfunction

   // Scanned high to low so the lowest-numbered matching port wins.
   function automatic logic [DATA_W-1:0] cdb_val(input logic [TAG_BITS-1:0] t);
      logic [DATA_W-1:0] v;
      v = '0;
      for (int k = N_CDB-1; k >= 0; k--)
         if (cdb_valid[k] && cdb_tag[k*TAG_BITS +: TAG_BITS] == t) v = cdb_data[k*DATA_W +: DATA_W];
      return v;
   endfunction

   assign rh          = rs_head[RPW-1:0];
   assign rs_count    = rs_tail - rs_head;
   assign sq_count    = sq_tail - sq_head;
   assign rs_empty    = (rs_head == rs_tail);
   assign alloc_ready = !((rs_head[RPW] != rs_tail[RPW]) && (rs_head[RPW-1:0] == rs_tail[RPW-1:0]));
   assign sq_full     = (sq_head[SPW] != sq_tail[SPW]) && (sq_head[SPW-1:0] == sq_tail[SPW-1:0]);

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      alloc_e          = '0;
      alloc_e.is_store = alloc_is_store;
      alloc_e.tag      = alloc_tag;
      alloc_e.base_tag = alloc_base_tag;
      alloc_e.data_tag = alloc_data_tag;
      alloc_e.addr_rdy = alloc_base_rdy | cdb_hit(alloc_base_tag);
      alloc_e.addr     = alloc_offset + ADDR_W'(alloc_base_rdy ? alloc_base_val : cdb_val(alloc_base_tag));
      alloc_e.data_rdy = alloc_data_rdy | cdb_hit(alloc_data_tag);
      alloc_e.data     = alloc_data_rdy ? alloc_data_val : cdb_val(alloc_data_tag);
   end

   // Oldest-to-youngest scan: a later (younger) match overwrites an earlier one.
   always_comb begin
      fwd_hit = 1'b0;
      fwd_val = '0;
      fidx    = '0;
      for (int i = 0; i < SQ_DEPTH; i++) begin
         fidx = sq_head[SPW-1:0] + SPW'(i);
         if ((SPW+1)'(i) < sq_count && sq_mem[fidx].addr[ADDR_W-1:2] == rs_mem[rh].addr[ADDR_W-1:2]) begin
            fwd_hit = 1'b1;
            fwd_val = sq_mem[fidx].data;
         end
      end
   end

   assign req_load_en = !dc_req_valid | dc_req_ready;
   assign wr_inflight = dc_req_valid & dc_req_write;
   assign wr_free     = wr_inflight & dc_req_ready;
   assign cmt_cnt     = sq_cmt - sq_head;
   // An in-flight write is always the SQ head, so the next candidate sits just behind it.
   assign wr_idx      = sq_head[SPW-1:0] + SPW'(wr_inflight);
   assign issue_wr    = req_load_en & (cmt_cnt > {{SPW{1'b0}}, wr_inflight});
   assign head_ok     = !rs_empty & !flush & rs_mem[rh].addr_rdy & (!rs_mem[rh].is_store | rs_mem[rh].data_rdy);
   assign push_st     = head_ok & rs_mem[rh].is_store & !sq_full;
   assign do_fwd      = head_ok & !rs_mem[rh].is_store & fwd_hit;
   assign issue_ld    = head_ok & !rs_mem[rh].is_store & !fwd_hit & req_load_en & !issue_wr;
   assign rs_pop      = push_st | do_fwd | issue_ld;
   assign do_alloc    = alloc_valid & alloc_ready & !flush;
   assign do_commit   = commit_st & (sq_cmt != sq_tail);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rs_head       <= '0;
         rs_tail       <= '0;
         sq_head       <= '0;
         sq_tail       <= '0;
         sq_cmt        <= '0;
         st_done_valid <= 1'b0;
         st_done_tag   <= '0;
         fwd_valid     <= 1'b0;
         fwd_tag       <= '0;
         fwd_data      <= '0;
         dc_req_valid  <= 1'b0;
         dc_req_write  <= 1'b0;
         dc_req_addr   <= '0;
         dc_req_data   <= '0;
         dc_req_tag    <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every read sees pre-edge values.
         if (flush) begin
            rs_head <= '0;
            rs_tail <= '0;
            sq_tail <= sq_cmt + (SPW+1)'(do_commit);
         end else begin
            rs_head <= rs_head + (RPW+1)'(rs_pop);
            rs_tail <= rs_tail + (RPW+1)'(do_alloc);
            sq_tail <= sq_tail + (SPW+1)'(push_st);
         end
         sq_head       <= sq_head + (SPW+1)'(wr_free);
         sq_cmt        <= sq_cmt + (SPW+1)'(do_commit);
         st_done_valid <= push_st;
         st_done_tag   <= rs_mem[rh].tag;
         fwd_valid     <= do_fwd;
         fwd_tag       <= rs_mem[rh].tag;
         fwd_data      <= fwd_val;
         if (issue_wr) begin
            dc_req_valid <= 1'b1;
            dc_req_write <= 1'b1;
            dc_req_addr  <= sq_mem[wr_idx].addr;
            dc_req_data  <= sq_mem[wr_idx].data;
            dc_req_tag   <= '0;
         end else if (issue_ld) begin
            dc_req_valid <= 1'b1;
            dc_req_write <= 1'b0;
            dc_req_addr  <= rs_mem[rh].addr;
            dc_req_data  <= '0;
            dc_req_tag   <= rs_mem[rh].tag;
         end else if (req_load_en || (flush && !dc_req_write)) begin
            dc_req_valid <= 1'b0;
         end
      end
   end

   // NOTE: entry storage has no reset; pointers alone decide which entries are live.
   always_ff @(posedge clk) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
         if (!rs_mem[i].addr_rdy && cdb_hit(rs_mem[i].base_tag)) begin
            rs_mem[i].addr_rdy <= 1'b1;
            rs_mem[i].addr     <= rs_mem[i].addr + ADDR_W'(cdb_val(rs_mem[i].base_tag));
         end
         if (!rs_mem[i].data_rdy && cdb_hit(rs_mem[i].data_tag)) begin
            rs_mem[i].data_rdy <= 1'b1;
            rs_mem[i].data     <= cdb_val(rs_mem[i].data_tag);
         end
      end
      if (do_alloc) rs_mem[rs_tail[RPW-1:0]] <= alloc_e;
      if (push_st) sq_mem[sq_tail[SPW-1:0]] <= '{addr: rs_mem[rh].addr, data: rs_mem[rh].data};
   end
endmodule

// File: tb/tb_mem_lsq_station.sv
// Bench for mem_lsq_station: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_lsq_station;
   localparam int RS_DEPTH = 8;
   localparam int SQ_DEPTH = 8;

   logic clk = 1'b0;
   logic rst_n, flush, alloc_valid, alloc_ready, alloc_is_store;
   logic [3:0] alloc_tag, alloc_base_tag, alloc_data_tag;
   logic [31:0] alloc_offset, alloc_base_val, alloc_data_val;
   logic alloc_base_rdy, alloc_data_rdy;
   logic [1:0] cdb_valid;
   logic [7:0] cdb_tag;
   logic [63:0] cdb_data;
   logic st_done_valid, commit_st, dc_req_valid, dc_req_ready, dc_req_write, fwd_valid;
   logic [3:0] st_done_tag, dc_req_tag, fwd_tag;
   logic [31:0] dc_req_addr, dc_req_data, fwd_data;
   logic [3:0] rs_count, sq_count;

   mem_lsq_station dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_is_store(alloc_is_store),
      .alloc_tag(alloc_tag), .alloc_offset(alloc_offset),
      .alloc_base_rdy(alloc_base_rdy), .alloc_base_val(alloc_base_val), .alloc_base_tag(alloc_base_tag),
      .alloc_data_rdy(alloc_data_rdy), .alloc_data_val(alloc_data_val), .alloc_data_tag(alloc_data_tag),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .st_done_valid(st_done_valid), .st_done_tag(st_done_tag), .commit_st(commit_st),
      .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_write(dc_req_write),
      .dc_req_addr(dc_req_addr), .dc_req_data(dc_req_data), .dc_req_tag(dc_req_tag),
      .fwd_valid(fwd_valid), .fwd_tag(fwd_tag), .fwd_data(fwd_data),
      .rs_count(rs_count), .sq_count(sq_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic st; logic [3:0] tag;
      logic ar; logic [3:0] btag; logic [31:0] addr;
      logic dr; logic [3:0] dtag; logic [31:0] data;
   } rs_t;
   typedef struct { logic [31:0] addr; logic [31:0] data; logic cm; } sq_t;
   typedef struct { logic v; logic w; logic [31:0] addr; logic [31:0] data; logic [3:0] tag; } req_t;

   rs_t  m_rs[$];
   sq_t  m_sq[$];
   req_t m_req;
   logic m_fwd_v, m_sd_v;
   logic [3:0] m_fwd_tag, m_sd_tag;
   logic [31:0] m_fwd_data;

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Lowest-numbered valid port carrying the tag supplies the value.
   function automatic bit m_cdb(input logic [3:0] t, output logic [31:0] d);
      d = '0;
      for (int k = 0; k < 2; k++)
         if (cdb_valid[k] && cdb_tag[k*4 +: 4] == t) begin
            d = cdb_data[k*32 +: 32];
            return 1'b1;
         end
      return 1'b0;
   endfunction

   task automatic model_step();
      rs_t h, ne;
      sq_t wc;
      logic [31:0] d, fd;
      bit hit, load_en, wr_go, st_go, fw_go, ld_go, acc;
      int wi, old_rs;
      if (!rst_n) begin
         m_rs.delete(); m_sq.delete();
         m_req = '{1'b0, 1'b0, 32'h0, 32'h0, 4'h0};
         m_fwd_v = 0; m_sd_v = 0;
      end else begin
         load_en = !m_req.v || dc_req_ready;
         acc     = m_req.v && dc_req_ready && m_req.w;
         wi      = (m_req.v && m_req.w) ? 1 : 0;
         wr_go   = load_en && (m_sq.size() > wi) && m_sq[wi].cm;
         if (wr_go) wc = m_sq[wi];
         st_go = 0; fw_go = 0; ld_go = 0; fd = '0;
         old_rs = m_rs.size();
         if (old_rs > 0 && !flush) begin
            h = m_rs[0];
            if (h.ar && (!h.st || h.dr)) begin
               if (h.st) st_go = (m_sq.size() < SQ_DEPTH);
               else begin
                  for (int i = m_sq.size()-1; i >= 0; i--)
                     if (m_sq[i].addr[31:2] == h.addr[31:2]) begin
                        fw_go = 1; fd = m_sq[i].data; break;
                     end
                  if (!fw_go) ld_go = load_en && !wr_go;
               end
            end
         end
         m_sd_v = st_go;  if (st_go) m_sd_tag = h.tag;
         m_fwd_v = fw_go; if (fw_go) begin m_fwd_tag = h.tag; m_fwd_data = fd; end
         if (m_req.v && dc_req_ready) m_req.v = 0;
         if (flush && m_req.v && !m_req.w) m_req.v = 0;
         if (wr_go) m_req = '{1'b1, 1'b1, wc.addr, wc.data, 4'h0};
         else if (ld_go) m_req = '{1'b1, 1'b0, h.addr, 32'h0, h.tag};
         // store queue: free, commit, push, squash
         if (acc) void'(m_sq.pop_front());
         if (commit_st)
            for (int i = 0; i < m_sq.size(); i++)
               if (!m_sq[i].cm) begin m_sq[i].cm = 1; break; end
         if (st_go) m_sq.push_back('{h.addr, h.data, 1'b0});
         if (flush) while (m_sq.size() > 0 && !m_sq[m_sq.size()-1].cm) void'(m_sq.pop_back());
         // station: wakeup, pop, allocate, squash
         for (int i = 0; i < m_rs.size(); i++) begin
            if (!m_rs[i].ar && m_cdb(m_rs[i].btag, d)) begin m_rs[i].ar = 1; m_rs[i].addr += d; end
            if (!m_rs[i].dr && m_cdb(m_rs[i].dtag, d)) begin m_rs[i].dr = 1; m_rs[i].data = d; end
         end
         if (st_go || fw_go || ld_go) void'(m_rs.pop_front());
         if (alloc_valid && old_rs < RS_DEPTH && !flush) begin
            ne.st = alloc_is_store; ne.tag = alloc_tag; ne.btag = alloc_base_tag; ne.dtag = alloc_data_tag;
            hit = m_cdb(alloc_base_tag, d);
            ne.ar = alloc_base_rdy || hit;
            ne.addr = alloc_offset + (alloc_base_rdy ? alloc_base_val : d);
            hit = m_cdb(alloc_data_tag, d);
            ne.dr = alloc_data_rdy || hit;
            ne.data = alloc_data_rdy ? alloc_data_val : d;
            m_rs.push_back(ne);
         end
         if (flush) m_rs.delete();
      end
   endtask

   always @(negedge clk) if (chk_en) begin
      check("alloc_ready", alloc_ready, m_rs.size() < RS_DEPTH);
      check("rs_count", rs_count, m_rs.size());
      check("sq_count", sq_count, m_sq.size());
      check("dc_req_valid", dc_req_valid, m_req.v);
      if (m_req.v) begin
         check("dc_req_write", dc_req_write, m_req.w);
         check("dc_req_addr", dc_req_addr, m_req.addr);
         check("dc_req_tag", dc_req_tag, m_req.tag);
         if (m_req.w) check("dc_req_data", dc_req_data, m_req.data);
      end
      check("fwd_valid", fwd_valid, m_fwd_v);
      if (m_fwd_v) begin
         check("fwd_tag", fwd_tag, m_fwd_tag);
         check("fwd_data", fwd_data, m_fwd_data);
      end
      check("st_done_valid", st_done_valid, m_sd_v);
      if (m_sd_v) check("st_done_tag", st_done_tag, m_sd_tag);
   end

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle();
      flush = 0; alloc_valid = 0; alloc_is_store = 0; alloc_tag = 0; alloc_offset = 0;
      alloc_base_rdy = 0; alloc_base_val = 0; alloc_base_tag = 0;
      alloc_data_rdy = 0; alloc_data_val = 0; alloc_data_tag = 0;
      cdb_valid = 0; cdb_tag = 0; cdb_data = 0; commit_st = 0;
   endtask

   task automatic alloc(input logic st, input logic [3:0] tag, input logic [31:0] off,
                        input logic brdy, input logic [31:0] bval, input logic [3:0] btag,
                        input logic drdy, input logic [31:0] dval);
      alloc_valid = 1; alloc_is_store = st; alloc_tag = tag; alloc_offset = off;
      alloc_base_rdy = brdy; alloc_base_val = bval; alloc_base_tag = btag;
      alloc_data_rdy = drdy; alloc_data_val = dval; alloc_data_tag = 4'hF;
   endtask

   task automatic clean();
      idle(); flush = 1; cycle(); idle(); cycle();
   endtask

   initial begin
      idle(); dc_req_ready = 1; rst_n = 0;
      cycle(); cycle();
      rst_n = 1; chk_en = 1;
      check("reset_alloc_ready", alloc_ready, 1'b1);
      check("reset_rs_count", rs_count, 0);

      // load: base 0x100 + offset 4
      alloc(0, 4'd5, 32'h4, 1, 32'h100, 4'd0, 0, 0); cycle();
      idle(); cycle();
      check("ld_req_valid", dc_req_valid, 1'b1);
      check("ld_req_addr", dc_req_addr, 32'h104);
      check("ld_req_write", dc_req_write, 1'b0);
      check("ld_req_tag", dc_req_tag, 4'd5);
      cycle();

      // store to 0x200 then load 0x202 forwards
      alloc(1, 4'd3, 32'h0, 1, 32'h200, 4'd0, 1, 32'hAB); cycle();
      idle(); cycle();
      check("st_done_valid", st_done_valid, 1'b1);
      check("st_done_tag", st_done_tag, 4'd3);
      alloc(0, 4'd6, 32'h2, 1, 32'h200, 4'd0, 0, 0); cycle();
      idle(); cycle();
      check("fwd_valid", fwd_valid, 1'b1);
      check("fwd_tag", fwd_tag, 4'd6);
      check("fwd_data", fwd_data, 32'hAB);
      check("fwd_no_cache", dc_req_valid, 1'b0);
      clean();

      // fill station with loads waiting on tag 9, wake via CDB port 1
      for (int i = 0; i < RS_DEPTH; i++) begin
         alloc(0, 4'(i), 32'(i*8), 0, 32'h0, 4'd9, 0, 0); cycle();
      end
      idle();
      check("full_alloc_ready", alloc_ready, 1'b0);
      check("full_rs_count", rs_count, RS_DEPTH);
      cdb_valid = 2'b10; cdb_tag = 8'h90; cdb_data = {32'h300, 32'h0}; cycle();
      idle(); cycle();
      check("wake_req_valid", dc_req_valid, 1'b1);
      check("wake_req_addr", dc_req_addr, 32'h300);
      check("wake_alloc_ready", alloc_ready, 1'b1);
      clean();

      // two committed stores held behind dc_req_ready=0, then drained in order
      dc_req_ready = 0;
      alloc(1, 4'd1, 32'h0, 1, 32'h400, 4'd0, 1, 32'h11); cycle();
      alloc(1, 4'd2, 32'h0, 1, 32'h404, 4'd0, 1, 32'h22); cycle();
      idle(); cycle();
      commit_st = 1; cycle(); cycle();
      commit_st = 0;
      check("drain_sq2", sq_count, 2);
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("stall_valid", dc_req_valid, 1'b1);
         check("stall_addr", dc_req_addr, 32'h400);
         check("stall_data", dc_req_data, 32'h11);
      end
      dc_req_ready = 1; cycle();
      check("drain_sq1", sq_count, 1);
      check("drain_addr2", dc_req_addr, 32'h404);
      cycle();
      check("drain_sq0", sq_count, 0);
      check("drain_idle", dc_req_valid, 1'b0);

      // flush keeps the committed store and its write
      dc_req_ready = 0;
      alloc(1, 4'd1, 32'h0, 1, 32'h500, 4'd0, 1, 32'hA5); cycle();
      alloc(1, 4'd2, 32'h0, 1, 32'h504, 4'd0, 1, 32'hB6); cycle();
      idle(); cycle();
      commit_st = 1; cycle();
      idle(); alloc(0, 4'd7, 32'h0, 0, 32'h0, 4'd12, 0, 0); cycle();
      idle(); flush = 1; cycle();
      flush = 0;
      check("flush_sq_count", sq_count, 1);
      check("flush_rs_count", rs_count, 0);
      check("flush_wr_valid", dc_req_valid, 1'b1);
      check("flush_wr_addr", dc_req_addr, 32'h500);
      dc_req_ready = 1; cycle();
      check("flush_drained", sq_count, 0);
      cycle();

      // reset while a request is pending
      dc_req_ready = 0;
      alloc(0, 4'd4, 32'h0, 1, 32'h600, 4'd0, 0, 0); cycle();
      idle(); cycle();
      check("prerst_valid", dc_req_valid, 1'b1);
      rst_n = 0; cycle();
      rst_n = 1;
      check("rst_req_valid", dc_req_valid, 1'b0);
      check("rst_fwd_valid", fwd_valid, 1'b0);
      check("rst_st_done", st_done_valid, 1'b0);
      check("rst_alloc_ready", alloc_ready, 1'b1);
      check("rst_counts", {rs_count, sq_count}, 8'h00);

      // randomized traffic
      for (int c = 0; c < 4000; c++) begin
         idle();
         if ($urandom_range(0, 99) < 50)
            alloc($urandom_range(0, 1), 4'($urandom_range(0, 15)), 32'($urandom_range(0, 15)),
                  $urandom_range(0, 99) < 70, 32'h100 + 32'($urandom_range(0, 3) * 4), 4'($urandom_range(0, 15)),
                  $urandom_range(0, 99) < 70, $urandom());
         alloc_data_tag = 4'($urandom_range(0, 15));
         for (int k = 0; k < 2; k++) begin
            cdb_valid[k] = $urandom_range(0, 99) < 40;
            cdb_tag[k*4 +: 4] = 4'($urandom_range(0, 15));
            cdb_data[k*32 +: 32] = 32'h100 + 32'($urandom_range(0, 15));
         end
         commit_st = $urandom_range(0, 99) < 20;
         flush = $urandom_range(0, 99) < 2;
         dc_req_ready = $urandom_range(0, 99) < 60;
         cycle();
      end
      idle(); dc_req_ready = 1;
      cycle(); cycle();
      chk_en = 0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
